// File: rtl/mem_hold_arbiter.sv
// rtl/mem_hold_arbiter.sv - HOLD/HLDA based RAM port arbiter for two bus masters
//
// Shares the CPU-side RAM port between the 8088 and two masters
// (0 = DMA, 1 = UART loader). Requests HOLD, waits for HLDA, grants one
// master at a time round-robin with an optional tenure limit, and steers
// RAM address/data/write-enable to the current owner.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req[1:0]                  level requests (bit0 DMA, bit1 loader)
//   gnt[1:0]                  one-hot grant
//   cpu_hold / cpu_hlda       HOLD to CPU / HLDA from CPU
//   cpu_ram_addr/data/wren    CPU-side RAM access from system_bus
//   m0_*/m1_*                 master RAM accesses
//   ram_addr/data/wren        RAM port
//   busy                      arbiter not idle
//   hlda_err                  sticky HLDA timeout flag
module mem_hold_arbiter #(
    parameter int AW           = 14,
    parameter int DW           = 8,
    parameter int MAX_TENURE   = 64,
    parameter int HLDA_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic          cpu_hold,
    input  logic          cpu_hlda,
    input  logic [AW-1:0] cpu_ram_addr,
    input  logic [DW-1:0] cpu_ram_data,
    input  logic          cpu_ram_wren,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_data,
    input  logic          m0_wren,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_data,
    input  logic          m1_wren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    output logic          busy,
    output logic          hlda_err
);

    localparam int CNT_MAX = (MAX_TENURE > HLDA_TIMEOUT) ? MAX_TENURE : HLDA_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(HLDA_TIMEOUT - 1);
    localparam logic [CW-1:0] TEN_LAST = CW'(MAX_TENURE - 1);
    // With a tenure limit the count parks on the preemption value so a
    // late-arriving competitor still triggers preemption; unlimited tenure
    // simply parks at all ones.
    localparam logic [CW-1:0] TEN_SAT  = (MAX_TENURE != 0) ? TEN_LAST : {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD_REQ = 2'd1,
        S_GRANT    = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;   // HLDA wait timer in HOLD_REQ, tenure in GRANT
    logic          err_q, err_d;

    logic req_own;
    logic req_oth;
    logic preempt;

    assign req_own = req[owner_q];
    assign req_oth = req[~owner_q];
    assign preempt = (MAX_TENURE != 0) && (cnt_q == TEN_LAST) && req_oth;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = (req == 2'b11) ? ~last_q : req[1];
                    cnt_d   = '0;
                    state_d = S_HOLD_REQ;
                end
            end
            S_HOLD_REQ: begin
                // A withdrawn request wins over a simultaneous HLDA.
                if (!req_own) begin
                    state_d = S_RELEASE;
                end else if (cpu_hlda) begin
                    state_d = S_GRANT;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GRANT: begin
                // Losing HLDA mid-grant means the CPU took the bus back.
                if (!req_own || !cpu_hlda || preempt) begin
                    state_d = S_RELEASE;
                end else if (cnt_q != TEN_SAT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                if (!cpu_hlda) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Steering depends only on registered state/owner, never on req.
    always_comb begin
        gnt      = 2'b00;
        cpu_hold = 1'b0;
        busy     = (state_q != S_IDLE);
        ram_addr = cpu_ram_addr;
        ram_data = cpu_ram_data;
        ram_wren = cpu_ram_wren;
        case (state_q)
            S_HOLD_REQ: begin
                cpu_hold = 1'b1;
            end
            S_GRANT: begin
                cpu_hold       = 1'b1;
                gnt[owner_q]   = 1'b1;
                ram_addr       = owner_q ? m1_addr : m0_addr;
                ram_data       = owner_q ? m1_data : m0_data;
                ram_wren       = owner_q ? m1_wren : m0_wren;
            end
            S_RELEASE: begin
                ram_wren = 1'b0;
            end
            default: ;
        endcase
    end

    assign hlda_err = err_q;

endmodule
